// File: rtl/mips_pkg.sv
// Shared pipeline definitions for the execute stage.
// Contents:
//   alu_op_e     - ALU operation codes carried in id_ex_alu_op
//   mul_state_e  - encodings for the iterative multiplier FSM
//   FWD_*        - forwarding select values
//   fwd_sel()    - operand forwarding mux (11 behaves like 00)
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_NOR = 4'b0101,
    ALU_SLT = 4'b0110,
    ALU_SLL = 4'b0111,
    ALU_SRL = 4'b1000,
    ALU_LUI = 4'b1001,
    ALU_MUL = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  function automatic logic [31:0] fwd_sel(
    input logic [1:0]  sel,
    input logic [31:0] reg_data,
    input logic [31:0] mem_data,
    input logic [31:0] wb_data
  );
    logic [31:0] result;
    case (sel)
      FWD_MEM: result = mem_data;
      FWD_WB:  result = wb_data;
      default: result = reg_data;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative 32x32 shift-add multiplier (low 32 bits of the product).
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   start             - accepted only in IDLE; latches a and b on that edge
//   a, b              - multiplicand / multiplier
//   busy              - high while in BUSY (32 shift-add steps)
//   done              - high for the single DONE cycle; product is valid then
//   product           - accumulated result
module mul_iter
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  mul_state_e  state_reg, state_next;
  logic [4:0]  count_reg;
  logic [31:0] acc_reg;
  logic [31:0] mcand_reg;
  logic [31:0] mplier_reg;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= MUL_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MUL_IDLE: if (start) state_next = MUL_BUSY;
      MUL_BUSY: if (count_reg == 5'd31) state_next = MUL_DONE;
      MUL_DONE: state_next = MUL_IDLE;
      default:  state_next = MUL_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy    = (state_reg == MUL_BUSY);
    done    = (state_reg == MUL_DONE);
    product = acc_reg;
  end

  // Datapath: one shift-add step per BUSY cycle; the counter wraps back to 0
  // after the 32nd step so it is ready for the next operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg  <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
    end else if (state_reg == MUL_IDLE && start) begin
      count_reg  <= '0;
      acc_reg    <= '0;
      mcand_reg  <= a;
      mplier_reg <= b;
    end else if (state_reg == MUL_BUSY) begin
      if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg + 5'd1;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, branch resolution,
// iterative multiplier with pipeline stall, and the EX/MEM register.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   id_ex_*                    - instruction held in ID/EX
//   forward_a/b, *_fwd_data    - forwarding selects and forwarded values
//   ex_mem_*                   - registered EX/MEM outputs
//   branch_taken/branch_target - combinational branch resolution
//   ex_stall                   - combinational hold for PC, IF/ID, ID/EX
module ex_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        id_ex_valid,
  input  logic [31:0] id_ex_rs_data,
  input  logic [31:0] id_ex_rt_data,
  input  logic [31:0] id_ex_imm,
  input  logic [31:0] id_ex_pc_plus4,
  input  logic [4:0]  id_ex_regdst,
  input  logic [3:0]  id_ex_alu_op,
  input  logic        id_ex_alu_src,
  input  logic        id_ex_reg_write,
  input  logic        id_ex_mem_read,
  input  logic        id_ex_mem_write,
  input  logic        id_ex_mem_to_reg,
  input  logic        id_ex_branch,
  input  logic [1:0]  forward_a,
  input  logic [1:0]  forward_b,
  input  logic [31:0] mem_fwd_data,
  input  logic [31:0] wb_fwd_data,
  output logic        ex_mem_valid,
  output logic        ex_mem_reg_write,
  output logic        ex_mem_mem_read,
  output logic        ex_mem_mem_write,
  output logic        ex_mem_mem_to_reg,
  output logic [31:0] ex_mem_alu_result,
  output logic [31:0] ex_mem_store_data,
  output logic [4:0]  ex_mem_regdst,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        ex_stall
);

  logic [31:0] op_a, fwd_b, op_b, alu_result, product;
  logic [4:0]  shamt;
  logic        mul_busy, mul_done, mul_start;

  // Controls of the MUL in flight, captured at start and replayed in DONE
  logic        mul_reg_write_reg, mul_mem_read_reg, mul_mem_write_reg, mul_mem_to_reg_reg;
  logic [4:0]  mul_regdst_reg;
  logic [31:0] mul_store_reg;

  assign op_a  = fwd_sel(forward_a, id_ex_rs_data, mem_fwd_data, wb_fwd_data);
  assign fwd_b = fwd_sel(forward_b, id_ex_rt_data, mem_fwd_data, wb_fwd_data);
  assign op_b  = id_ex_alu_src ? id_ex_imm : fwd_b;
  assign shamt = id_ex_imm[10:6];

  // A MUL may only start from IDLE; in DONE the same MUL is still in ID/EX
  // and must not be restarted.
  assign mul_start = id_ex_valid && (id_ex_alu_op == ALU_MUL) && !mul_busy && !mul_done;
  assign ex_stall  = !reset && (mul_busy || mul_start);

  // Gating with ex_stall keeps a flush and a hold from ever coinciding.
  assign branch_taken  = id_ex_valid && id_ex_branch && (op_a == op_b) && !ex_stall;
  assign branch_target = id_ex_pc_plus4 + (id_ex_imm << 2);

  always_comb begin
    alu_result = '0;
    case (id_ex_alu_op)
      ALU_ADD: alu_result = op_a + op_b;
      ALU_SUB: alu_result = op_a - op_b;
      ALU_AND: alu_result = op_a & op_b;
      ALU_OR:  alu_result = op_a | op_b;
      ALU_XOR: alu_result = op_a ^ op_b;
      ALU_NOR: alu_result = ~(op_a | op_b);
      ALU_SLT: alu_result = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
      ALU_SLL: alu_result = op_b << shamt;
      ALU_SRL: alu_result = op_b >> shamt;
      ALU_LUI: alu_result = {id_ex_imm[15:0], 16'h0000};
      default: alu_result = '0;  // MUL goes through mul_iter
    endcase
  end

  mul_iter u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_reg_write_reg  <= 1'b0;
      mul_mem_read_reg   <= 1'b0;
      mul_mem_write_reg  <= 1'b0;
      mul_mem_to_reg_reg <= 1'b0;
      mul_regdst_reg     <= '0;
      mul_store_reg      <= '0;
    end else if (mul_start) begin
      mul_reg_write_reg  <= id_ex_reg_write;
      mul_mem_read_reg   <= id_ex_mem_read;
      mul_mem_write_reg  <= id_ex_mem_write;
      mul_mem_to_reg_reg <= id_ex_mem_to_reg;
      mul_regdst_reg     <= id_ex_regdst;
      mul_store_reg      <= fwd_b;
    end
  end

  // EX/MEM register
  always_ff @(posedge clk) begin
    if (reset || (!mul_done && (ex_stall || !id_ex_valid))) begin
      ex_mem_valid      <= 1'b0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_read   <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
      ex_mem_mem_to_reg <= 1'b0;
      ex_mem_alu_result <= '0;
      ex_mem_store_data <= '0;
      ex_mem_regdst     <= '0;
    end else if (mul_done) begin
      ex_mem_valid      <= 1'b1;
      ex_mem_reg_write  <= mul_reg_write_reg;
      ex_mem_mem_read   <= mul_mem_read_reg;
      ex_mem_mem_write  <= mul_mem_write_reg;
      ex_mem_mem_to_reg <= mul_mem_to_reg_reg;
      ex_mem_alu_result <= product;
      ex_mem_store_data <= mul_store_reg;
      ex_mem_regdst     <= mul_regdst_reg;
    end else begin
      // A branch never writes the register file or memory.
      ex_mem_valid      <= 1'b1;
      ex_mem_reg_write  <= id_ex_reg_write && !id_ex_branch;
      ex_mem_mem_read   <= id_ex_mem_read;
      ex_mem_mem_write  <= id_ex_mem_write && !id_ex_branch;
      ex_mem_mem_to_reg <= id_ex_mem_to_reg;
      ex_mem_alu_result <= alu_result;
      ex_mem_store_data <= fwd_b;
      ex_mem_regdst     <= id_ex_regdst;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_ex_valid;
  logic [31:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_pc_plus4;
  logic [4:0]  id_ex_regdst;
  logic [3:0]  id_ex_alu_op;
  logic        id_ex_alu_src, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
  logic        id_ex_mem_to_reg, id_ex_branch;
  logic [1:0]  forward_a, forward_b;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write;
  logic        ex_mem_mem_to_reg;
  logic [31:0] ex_mem_alu_result, ex_mem_store_data;
  logic [4:0]  ex_mem_regdst;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ex_stall;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset), .id_ex_valid(id_ex_valid),
    .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data),
    .id_ex_imm(id_ex_imm), .id_ex_pc_plus4(id_ex_pc_plus4),
    .id_ex_regdst(id_ex_regdst), .id_ex_alu_op(id_ex_alu_op),
    .id_ex_alu_src(id_ex_alu_src), .id_ex_reg_write(id_ex_reg_write),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_mem_write(id_ex_mem_write),
    .id_ex_mem_to_reg(id_ex_mem_to_reg), .id_ex_branch(id_ex_branch),
    .forward_a(forward_a), .forward_b(forward_b),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .ex_mem_valid(ex_mem_valid), .ex_mem_reg_write(ex_mem_reg_write),
    .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write),
    .ex_mem_mem_to_reg(ex_mem_mem_to_reg), .ex_mem_alu_result(ex_mem_alu_result),
    .ex_mem_store_data(ex_mem_store_data), .ex_mem_regdst(ex_mem_regdst),
    .branch_taken(branch_taken), .branch_target(branch_target), .ex_stall(ex_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_ex_valid = 0; id_ex_rs_data = 0; id_ex_rt_data = 0; id_ex_imm = 0;
    id_ex_pc_plus4 = 0; id_ex_regdst = 0; id_ex_alu_op = 0; id_ex_alu_src = 0;
    id_ex_reg_write = 0; id_ex_mem_read = 0; id_ex_mem_write = 0;
    id_ex_mem_to_reg = 0; id_ex_branch = 0; forward_a = 0; forward_b = 0;
    mem_fwd_data = 0; wb_fwd_data = 0;
  endtask

  // Reference model
  function automatic logic [31:0] ref_pick(input logic [1:0] sel, input logic [31:0] r,
                                           input logic [31:0] m, input logic [31:0] w);
    if (sel == 2'd2) return m;
    if (sel == 2'd1) return w;
    return r;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
    longint unsigned pa, pb, full;
    int sh;
    sh = int'(imm[10:6]);
    pa = longint'(a); pb = longint'(b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  begin full = pb * (64'd1 << sh); return full[31:0]; end
      4'd8:  begin full = pb / (64'd1 << sh); return full[31:0]; end
      4'd9:  return imm * 32'd65536;
      4'd10: begin full = pa * pb; return full[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  // Runs one MUL with inputs held until the result appears.
  task automatic mul_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input bit disturb);
    int stalls, bubbles;
    bit got;
    logic [31:0] exp;
    exp = ref_alu(4'd10, a, b, 32'd0);
    clear_inputs();
    id_ex_valid = 1; id_ex_alu_op = 4'd10; id_ex_rs_data = a; id_ex_rt_data = b;
    id_ex_reg_write = 1; id_ex_regdst = 5'd5;
    stalls = 0; bubbles = 0; got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      #1;
      if (ex_stall) stalls++;
      if (disturb && k == 5) begin
        forward_a = 2'b01; forward_b = 2'b01; wb_fwd_data = 32'h0001_2345;
      end
      tick();
      if (ex_mem_valid) got = 1;
      else bubbles++;
    end
    id_ex_valid = 0; forward_a = 0; forward_b = 0;
    chk({tag, "_done"}, 32'(got), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'd33);
    chk({tag, "_bubbles"}, 32'(bubbles), 32'd33);
    chk({tag, "_result"}, ex_mem_alu_result, exp);
    chk({tag, "_reg_write"}, 32'(ex_mem_reg_write), 32'd1);
    chk({tag, "_regdst"}, 32'(ex_mem_regdst), 32'd5);
    $display("[TB] %s: %h x %h -> %h", tag, a, b, ex_mem_alu_result);
  endtask

  initial begin
    int hits;
    logic [31:0] ea, eb, efb;
    logic        eb_taken;

    // Reset
    clear_inputs();
    reset = 1;
    tick(); tick();
    chk("rst_valid", 32'(ex_mem_valid), 32'd0);
    chk("rst_result", ex_mem_alu_result, 32'd0);
    chk("rst_stall", 32'(ex_stall), 32'd0);
    reset = 0;
    $display("[TB] reset checked");

    // ADD 5+7
    id_ex_valid = 1; id_ex_alu_op = 4'd0; id_ex_rs_data = 5; id_ex_rt_data = 7;
    id_ex_reg_write = 1; id_ex_regdst = 5'd9;
    tick();
    chk("add_result", ex_mem_alu_result, 32'd12);
    chk("add_valid", 32'(ex_mem_valid), 32'd1);
    chk("add_regdst", 32'(ex_mem_regdst), 32'd9);
    chk("add_store", ex_mem_store_data, 32'd7);
    $display("[TB] add 5+7 -> %0d", ex_mem_alu_result);

    // SUB with MEM forward then WB forward
    id_ex_alu_op = 4'd1; id_ex_rt_data = 1; forward_a = 2'b10; mem_fwd_data = 100;
    tick();
    chk("sub_fwd_mem", ex_mem_alu_result, 32'd99);
    $display("[TB] sub mem-fwd -> %0d", ex_mem_alu_result);
    forward_a = 2'b01; wb_fwd_data = 50;
    tick();
    chk("sub_fwd_wb", ex_mem_alu_result, 32'd49);
    $display("[TB] sub wb-fwd -> %0d", ex_mem_alu_result);

    // BEQ 3==3
    clear_inputs();
    id_ex_valid = 1; id_ex_alu_op = 4'd1; id_ex_rs_data = 3; id_ex_rt_data = 3;
    id_ex_imm = 4; id_ex_pc_plus4 = 32'h100; id_ex_branch = 1; id_ex_reg_write = 1;
    id_ex_mem_write = 1;
    #1;
    chk("beq_taken", 32'(branch_taken), 32'd1);
    chk("beq_target", branch_target, 32'h110);
    chk("beq_stall", 32'(ex_stall), 32'd0);
    tick();
    chk("beq_reg_write", 32'(ex_mem_reg_write), 32'd0);
    chk("beq_mem_write", 32'(ex_mem_mem_write), 32'd0);
    $display("[TB] beq -> taken target %h", branch_target);

    // Invalid instruction -> bubble
    id_ex_valid = 0; id_ex_branch = 0;
    #1;
    chk("inv_no_branch", 32'(branch_taken), 32'd0);
    tick();
    chk("inv_bubble", 32'(ex_mem_valid), 32'd0);
    chk("inv_reg_write", 32'(ex_mem_reg_write), 32'd0);
    $display("[TB] invalid -> bubble");

    // SLT -1 < 1
    clear_inputs();
    id_ex_valid = 1; id_ex_alu_op = 4'd6; id_ex_rs_data = 32'hFFFF_FFFF; id_ex_rt_data = 1;
    tick();
    chk("slt_result", ex_mem_alu_result, 32'd1);
    $display("[TB] slt -1<1 -> %0d", ex_mem_alu_result);

    // MULs
    mul_run("mul_6x7", 32'd6, 32'd7, 1'b1);
    chk("mul_6x7_exact", ex_mem_alu_result, 32'd42);
    tick();
    mul_run("mul_neg1x2", 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("mul_neg1x2_exact", ex_mem_alu_result, 32'hFFFF_FFFE);
    tick();

    // Reset in the 10th BUSY cycle
    clear_inputs();
    id_ex_valid = 1; id_ex_alu_op = 4'd10; id_ex_rs_data = 9; id_ex_rt_data = 9;
    id_ex_reg_write = 1;
    tick();              // now BUSY cycle 1
    repeat (9) tick();   // now BUSY cycle 10
    chk("rstmul_busy_stall", 32'(ex_stall), 32'd1);
    reset = 1;
    #1;
    chk("rstmul_stall_in_reset", 32'(ex_stall), 32'd0);
    tick();
    chk("rstmul_valid", 32'(ex_mem_valid), 32'd0);
    chk("rstmul_result", ex_mem_alu_result, 32'd0);
    chk("rstmul_reg_write", 32'(ex_mem_reg_write), 32'd0);
    reset = 0; id_ex_valid = 0;
    hits = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ex_mem_valid || ex_stall) hits++;
    end
    chk("rstmul_no_result", 32'(hits), 32'd0);
    // An idle multiplier lets an ordinary op straight through.
    id_ex_valid = 1; id_ex_alu_op = 4'd2; id_ex_rs_data = 32'hF0F0; id_ex_rt_data = 32'hFF00;
    #1;
    chk("rstmul_idle_no_stall", 32'(ex_stall), 32'd0);
    tick();
    chk("rstmul_and_after", ex_mem_alu_result, 32'h0000_F000);
    $display("[TB] reset mid-MUL -> abandoned");

    // Randomized single-cycle ops against the reference model
    for (int n = 0; n < 80; n++) begin
      clear_inputs();
      id_ex_alu_op = 4'($urandom_range(0, 15));
      if (id_ex_alu_op == 4'd10) id_ex_alu_op = 4'd0;
      id_ex_valid = ($urandom_range(0, 7) != 0);
      id_ex_rs_data = $urandom; id_ex_rt_data = $urandom; id_ex_imm = $urandom;
      id_ex_pc_plus4 = $urandom; mem_fwd_data = $urandom; wb_fwd_data = $urandom;
      forward_a = 2'($urandom_range(0, 3)); forward_b = 2'($urandom_range(0, 3));
      id_ex_alu_src = 1'($urandom_range(0, 1));
      id_ex_branch = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        id_ex_rt_data = id_ex_rs_data; forward_b = forward_a; id_ex_alu_src = 0;
      end
      id_ex_reg_write = 1'($urandom_range(0, 1));
      id_ex_mem_write = 1'($urandom_range(0, 1));
      id_ex_regdst = 5'($urandom_range(0, 31));
      ea  = ref_pick(forward_a, id_ex_rs_data, mem_fwd_data, wb_fwd_data);
      efb = ref_pick(forward_b, id_ex_rt_data, mem_fwd_data, wb_fwd_data);
      eb  = id_ex_alu_src ? id_ex_imm : efb;
      eb_taken = id_ex_valid && id_ex_branch && (ea == eb);
      #1;
      chk("rnd_branch_taken", 32'(branch_taken), 32'(eb_taken));
      chk("rnd_branch_target", branch_target, id_ex_pc_plus4 + id_ex_imm * 32'd4);
      chk("rnd_stall", 32'(ex_stall), 32'd0);
      tick();
      chk("rnd_valid", 32'(ex_mem_valid), 32'(id_ex_valid));
      chk("rnd_reg_write", 32'(ex_mem_reg_write),
          32'(id_ex_valid && id_ex_reg_write && !id_ex_branch));
      chk("rnd_mem_write", 32'(ex_mem_mem_write),
          32'(id_ex_valid && id_ex_mem_write && !id_ex_branch));
      if (id_ex_valid) begin
        chk("rnd_result", ex_mem_alu_result, ref_alu(id_ex_alu_op, ea, eb, id_ex_imm));
        chk("rnd_store", ex_mem_store_data, efb);
        chk("rnd_regdst", 32'(ex_mem_regdst), 32'(id_ex_regdst));
      end
      $display("[TB] rnd %0d op=%0d v=%0b a=%h b=%h -> %h", n, id_ex_alu_op, id_ex_valid,
               ea, eb, ex_mem_alu_result);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning), with one clock and a synchronous, active-high reset:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- id_ex_valid  in  1  ID/EX holds a real instruction
- id_ex_rs_data, id_ex_rt_data  in  32  register-file operands
- id_ex_imm  in  32  sign-extended immediate
- id_ex_pc_plus4  in  32  PC+4 of the instruction
- id_ex_regdst  in  5  destination register
- id_ex_alu_op  in  4  ALU operation code
- id_ex_alu_src  in  1  1 = operand B is the immediate
- id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_branch  in  1 each  control bits
- forward_a, forward_b  in  2  forwarding selects (00 register file, 10 MEM, 01 WB)
- mem_fwd_data, wb_fwd_data  in  32  forwarded values
- ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write, ex_mem_mem_to_reg  out  1 each  registered controls
- ex_mem_alu_result, ex_mem_store_data  out  32  registered result and forwarded Rt
- ex_mem_regdst  out  5  registered destination
- branch_taken  out  1  combinational flush request to IF/ID and ID/EX
- branch_target  out  32  combinational branch target
- ex_stall  out  1  combinational hold for PC, IF/ID and ID/EX

Function
REQ-002 SHALL form opA as: forward_a 10 selects mem_fwd_data, 01 selects wb_fwd_data, otherwise id_ex_rs_data (11 behaves as 00).
REQ-003 SHALL form fwdB with the same rule using forward_b and id_ex_rt_data; opB SHALL be id_ex_imm when alu_src=1, else fwdB.
REQ-004 SHALL implement these ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, NOR 0101, SLT 0110 (signed, result 0/1), SLL 0111 (opB << imm[10:6]), SRL 1000 (logical), LUI 1001 ({imm[15:0],16'h0}), MUL 1010 (low 32 bits of the product); all other codes SHALL yield 0.
REQ-005 SHALL use 32-bit wrap-around arithmetic with no overflow trap.
REQ-006 SHALL register every non-MUL result into EX/MEM on the next rising edge (1-cycle latency); ex_mem_store_data SHALL be fwdB.
REQ-007 SHALL drive branch_taken = id_ex_valid & id_ex_branch & (opA==opB) and branch_target = id_ex_pc_plus4 + (id_ex_imm<<2); the branch itself SHALL enter EX/MEM with reg_write=0 and mem_write=0.
REQ-008 SHALL run MUL as an FSM with states IDLE, BUSY and DONE.
REQ-009 SHALL leave IDLE for BUSY when a valid MUL is in EX, capturing opA and opB at that edge.
REQ-010 SHALL perform one shift-add step per cycle in BUSY using a 5-bit counter, moving to DONE after 32 steps.
REQ-011 SHALL, in DONE, write the product into EX/MEM with the latched controls and return to IDLE.
REQ-012 SHALL assert ex_stall whenever the state is BUSY, or the state is IDLE and a valid MUL is in EX; ex_stall SHALL be 0 in DONE; a MUL therefore occupies 34 cycles.
REQ-013 SHALL load a bubble into EX/MEM (all valid/control outputs 0) on every cycle in which ex_stall=1.
REQ-014 SHALL use only the operands latched at MUL start and ignore forwarding changes while BUSY.
REQ-015 SHALL load a bubble into EX/MEM when id_ex_valid=0.
REQ-016 SHALL never assert branch_taken and ex_stall together.

Reset
REQ-017 SHALL, while reset=1 at a clock edge, clear all EX/MEM outputs to 0, set the FSM to IDLE and set the counter to 0.
REQ-018 SHALL, when reset occurs mid-MUL, abandon the operation and write no result.
REQ-019 SHALL hold ex_stall=0 during reset.

Structure
REQ-020 SHALL take the ALU op codes and FSM state encodings from the shared pipeline package (mips_pkg).
REQ-021 SHALL place the iterative multiplier in one sub-module, mul_iter (start, busy, done, product).

Verification
REQ-022 The bench SHALL cover:
- ADD with rs=5, rt=7, forward 00 -> ex_mem_alu_result=12 one cycle later.
- SUB with forward_a=10 (mem_fwd_data=100), rt_data=1 -> 99; forward_a=01 (wb_fwd_data=50) -> 49.
- BEQ with opA=opB=3, imm=4, pc_plus4=0x100 -> branch_taken=1, branch_target=0x110, ex_mem_reg_write=0.
- MUL 6x7 -> ex_stall high for 33 cycles, 33 bubbles, then result 42; wb_fwd_data changed while BUSY -> product unchanged.
- MUL 0xFFFFFFFF x 2 -> 0xFFFFFFFE; SLT -1<1 -> 1.
- reset at the 10th BUSY cycle -> outputs 0, state IDLE, no result written.
